// File: rtl/line_mem_responder_pkg.sv
// lc3b_types: shared line/address types, responder state encoding, byte-merge helper.
// No ports; imported by line_mem_responder_if, line_mem_array and line_mem_responder.
package lc3b_types;
  typedef logic [127:0] lc3b_line;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [11:0]  lc3b_wb_adr;
  typedef logic [15:0]  lc3b_word;
  typedef enum logic [1:0] {LMR_IDLE = 2'd0, LMR_WAIT = 2'd1, LMR_RESP = 2'd2} lc3b_lmr_state_t;
  localparam int LMR_MAX_LATENCY = 15;
  function automatic lc3b_line byte_merge(lc3b_line old_line, lc3b_c_line new_line, lc3b_word sel);
    lc3b_line m;
    for (int i = 0; i < 16; i++) m[8*i +: 8] = sel[i] ? new_line[8*i +: 8] : old_line[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/line_mem_responder_if.sv
// line_mem_responder_if: line memory request/response bus.
// master drives mem_read/mem_write/mem_address/mem_wdata/mem_sel; slave drives mem_resp/mem_rdata/proto_err.
interface line_mem_responder_if;
  import lc3b_types::*;
  logic       mem_read;
  logic       mem_write;
  lc3b_wb_adr mem_address;
  lc3b_c_line mem_wdata;
  lc3b_word   mem_sel;
  logic       mem_resp;
  lc3b_line   mem_rdata;
  logic       proto_err;
  modport master (output mem_read, mem_write, mem_address, mem_wdata, mem_sel,
                  input mem_resp, mem_rdata, proto_err);
  modport slave  (input mem_read, mem_write, mem_address, mem_wdata, mem_sel,
                  output mem_resp, mem_rdata, proto_err);
endinterface

// File: rtl/line_mem_array.sv
// line_mem_array: DEPTH_LINES x 128-bit store, one byte-enable write port, one registered read port.
// Ports: clk, rst_n (clears read register only), en_i (load read register), we_i, idx_i, wdata_i, sel_i, rdata_o.
module line_mem_array
  import lc3b_types::*;
#(
  parameter int DEPTH_LINES = 256,
  localparam int AW = $clog2(DEPTH_LINES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  lc3b_c_line    wdata_i,
  input  lc3b_word      sel_i,
  output lc3b_line      rdata_o
);
  lc3b_line mem_q [DEPTH_LINES];
  lc3b_line merged;
  lc3b_line rdata_q;
  assign merged = byte_merge(mem_q[idx_i], wdata_i, sel_i);
  always_ff @(posedge clk)
    if (we_i) mem_q[idx_i] <= merged;
  // a write returns the post-merge line so read&write sees its own update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else if (en_i) rdata_q <= we_i ? merged : mem_q[idx_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency line memory responder (IDLE/WAIT/RESP).
// Ports: clk, rst_n (async, active-low), bus (line_mem_responder_if.slave).
// Optional macro LINE_MEM_PROTOCOL_CHECK_EN enables the sticky proto_err checker.
module line_mem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  line_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_LINES);
  localparam int CW = $clog2(LMR_MAX_LATENCY + 1);
  localparam logic [1:0] IDLE = LMR_IDLE;
  localparam logic [1:0] WAIT = LMR_WAIT;
  localparam logic [1:0] RESP = LMR_RESP;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  lc3b_wb_adr    addr_q, addr_c;
  lc3b_c_line    wdata_q, wdata_c;
  lc3b_word      sel_q, sel_c;
  logic [1:0]    op_q;
  logic          req, accept, fire, wr_c;
  logic          unused_addr;
  assign req    = bus.mem_read | bus.mem_write;
  assign accept = state_q == IDLE && req;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LATENCY == 1 ? RESP : WAIT;
        cnt_d   = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
      end
      WAIT: begin
        state_d = cnt_q == '0 ? RESP : WAIT;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.mem_address;
        wdata_q <= bus.mem_wdata;
        sel_q   <= bus.mem_sel;
        op_q    <= {bus.mem_read, bus.mem_write};
      end
    end
  // LATENCY=1 goes IDLE->RESP on the accept edge, so the live bus fields feed the array then
  assign addr_c  = accept ? bus.mem_address : addr_q;
  assign wdata_c = accept ? bus.mem_wdata : wdata_q;
  assign sel_c   = accept ? bus.mem_sel : sel_q;
  assign wr_c    = accept ? bus.mem_write : op_q[0];
  // gated by rst_n so nothing commits while reset is held
  assign fire    = rst_n && state_d == RESP;
  assign unused_addr = ^addr_c;
  line_mem_array #(.DEPTH_LINES(DEPTH_LINES)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (fire),
    .we_i    (fire & wr_c),
    .idx_i   (addr_c[AW-1:0]),
    .wdata_i (wdata_c),
    .sel_i   (sel_c),
    .rdata_o (bus.mem_rdata)
  );
  assign bus.mem_resp = state_q == RESP;
`ifdef LINE_MEM_PROTOCOL_CHECK_EN
  logic err_q, err_d;
  always_comb
    err_d = err_q | (accept & bus.mem_read & bus.mem_write)
          | (state_q == WAIT && (!req || bus.mem_address != addr_q
             || {bus.mem_read, bus.mem_write} != op_q));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  assign bus.proto_err = err_q;
`else
  assign bus.proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: table-driven scoreboard bench for line_mem_responder.
module tb_line_mem_responder;
  import lc3b_types::*;
  localparam int LAT = 4;
`ifdef LINE_MEM_PROTOCOL_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif
  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [127:0] wdata;
    logic [15:0] sel;
    logic        chk;
    logic [127:0] exp;
  } vec_t;
  localparam logic [127:0] ASC  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] PART = 128'h0F0E0D0C0B0A0908070605040302AAAA;
  localparam logic [127:0] MIX  = {{8{8'h01}}, {8{8'hC3}}};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  line_mem_responder_if b0();
  line_mem_responder_if b1();
  line_mem_responder #(.DEPTH_LINES(256), .LATENCY(LAT)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  line_mem_responder #(.DEPTH_LINES(256), .LATENCY(1))   dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];
  vec_t tbl[12];

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  task automatic txn(input vec_t v, input string nm);
    int k;
    @(negedge clk);
    b0.mem_read    = v.rd;
    b0.mem_write   = v.wr;
    b0.mem_address = v.addr;
    b0.mem_wdata   = v.wdata;
    b0.mem_sel     = v.sel;
    if (v.chk) exp_q.push_back(v.exp);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!b0.mem_resp && k < 20);
    chk({nm, " latency"}, 128'(k), 128'(LAT));
    if (v.chk) chk({nm, " rdata"}, b0.mem_rdata, exp_q.pop_front());
    b0.mem_read  = 1'b0;
    b0.mem_write = 1'b0;
    @(negedge clk);
    chk({nm, " pulse_end"}, 128'(b0.mem_resp), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    tbl[0]  = '{1'b0, 1'b1, 12'h005, ASC,       16'hFFFF, 1'b0, '0};
    tbl[1]  = '{1'b1, 1'b0, 12'h005, '0,        16'h0000, 1'b1, ASC};
    tbl[2]  = '{1'b0, 1'b1, 12'h005, rep(8'hAA), 16'h0003, 1'b0, '0};
    tbl[3]  = '{1'b1, 1'b0, 12'h005, '0,        16'h0000, 1'b1, PART};
    tbl[4]  = '{1'b0, 1'b1, 12'h105, rep(8'h11), 16'hFFFF, 1'b0, '0};
    tbl[5]  = '{1'b1, 1'b0, 12'h005, '0,        16'h0000, 1'b1, rep(8'h11)};
    tbl[6]  = '{1'b0, 1'b1, 12'h020, rep(8'h5A), 16'hFFFF, 1'b0, '0};
    tbl[7]  = '{1'b0, 1'b1, 12'h020, rep(8'hFF), 16'h0000, 1'b0, '0};
    tbl[8]  = '{1'b1, 1'b0, 12'h020, '0,        16'h0000, 1'b1, rep(8'h5A)};
    tbl[9]  = '{1'b0, 1'b1, 12'h030, rep(8'h01), 16'hFFFF, 1'b0, '0};
    tbl[10] = '{1'b1, 1'b1, 12'h030, rep(8'hC3), 16'h00FF, 1'b1, MIX};
    tbl[11] = '{1'b1, 1'b0, 12'h030, '0,        16'h0000, 1'b1, MIX};
    b0.mem_read = 1'b0; b0.mem_write = 1'b0; b0.mem_address = '0; b0.mem_wdata = '0; b0.mem_sel = '0;
    b1.mem_read = 1'b0; b1.mem_write = 1'b0; b1.mem_address = '0; b1.mem_wdata = '0; b1.mem_sel = '0;
    repeat (3) @(negedge clk);
    chk("reset resp", 128'(b0.mem_resp), 128'(0));
    chk("reset rdata", b0.mem_rdata, '0);
    chk("reset proto_err", 128'(b0.proto_err), 128'(0));
    chk("reset resp1", 128'(b1.mem_resp), 128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) txn(tbl[i], $sformatf("vec%0d", i));
    chk("proto_err clean", 128'(b0.proto_err), 128'(0));
    txn(tbl[10], "vec10 rd&wr");
    chk("proto_err rd&wr", 128'(b0.proto_err), 128'(PCHK));
    txn(tbl[11], "vec11");
    chk("proto_err sticky", 128'(b0.proto_err), 128'(PCHK));
    // LATENCY=1 with request held: pulses at cycles 1 and 3, low at 2
    @(negedge clk);
    b1.mem_write = 1'b1; b1.mem_address = 12'h003; b1.mem_wdata = rep(8'h77); b1.mem_sel = 16'hFFFF;
    @(negedge clk); chk("lat1 wr c1", 128'(b1.mem_resp), 128'(1));
    @(negedge clk); chk("lat1 wr c2", 128'(b1.mem_resp), 128'(0));
    @(negedge clk); chk("lat1 wr c3", 128'(b1.mem_resp), 128'(1));
    b1.mem_write = 1'b0; b1.mem_read = 1'b1;
    @(negedge clk); chk("lat1 turn", 128'(b1.mem_resp), 128'(0));
    @(negedge clk); chk("lat1 rd c1", 128'(b1.mem_resp), 128'(1));
    chk("lat1 rd c1 data", b1.mem_rdata, rep(8'h77));
    @(negedge clk); chk("lat1 rd c2", 128'(b1.mem_resp), 128'(0));
    @(negedge clk); chk("lat1 rd c3", 128'(b1.mem_resp), 128'(1));
    chk("lat1 rd c3 data", b1.mem_rdata, rep(8'h77));
    b1.mem_read = 1'b0;
    // reset during WAIT of a write aborts it
    @(negedge clk);
    b0.mem_write = 1'b1; b0.mem_address = 12'h020; b0.mem_wdata = rep(8'hEE); b0.mem_sel = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b0;
    b0.mem_write = 1'b0;
    #1;
    chk("midwait reset rdata", b0.mem_rdata, '0);
    chk("midwait reset proto_err", 128'(b0.proto_err), 128'(0));
    seen = b0.mem_resp;
    repeat (3) begin @(negedge clk); seen |= b0.mem_resp; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); seen |= b0.mem_resp; end
    chk("midwait no resp", 128'(seen), 128'(0));
    txn(tbl[8], "after abort");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
